mem_stage_lsu: RTL and testbench
================================

MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 Parameter DATA_WIDTH, default 64, data path and register width.
REQ-002 Parameter ADDR_WIDTH, default 64, byte address width.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 i_clk  in  1  clock, all state on rising edge.
REQ-005 i_arst  in  1  synchronous active-high reset.
REQ-006 i_mem_access  in  1  memory-stage instruction is a load or store.
REQ-007 i_mem_we  in  1  1 = store, 0 = load.
REQ-008 i_func3  in  3  access size and sign: 0 LB/SB, 1 LH/SH, 2 LW/SW, 3 LD/SD, 4 LBU, 5 LHU, 6 LWU.
REQ-009 i_alu_result  in  ADDR_WIDTH  byte address.
REQ-010 i_write_data  in  DATA_WIDTH  store data, right-justified.
REQ-011 o_req_valid  out  1  cache request valid.
REQ-012 i_req_ready  in  1  cache accepts request.
REQ-013 o_req_we  out  1  request is a store.
REQ-014 o_req_addr  out  ADDR_WIDTH  doubleword-aligned address, {addr[63:3], 3'b000}.
REQ-015 o_req_wdata  out  DATA_WIDTH  store data shifted to byte lane.
REQ-016 o_req_wstrb  out  8  byte-enable mask.
REQ-017 i_resp_valid  in  1  cache response valid, for loads and stores.
REQ-018 i_resp_data  in  DATA_WIDTH  raw doubleword read data.
REQ-019 o_stall_mem  out  1  holds the upstream memory pipeline register.
REQ-020 o_load_data  out  DATA_WIDTH  aligned and extended load result.
REQ-021 o_done  out  1  one-cycle pulse; access complete.
REQ-022 o_exception  out  1  misaligned or illegal access.
REQ-023 o_cause  out  4  exception code: 4 load misaligned, 6 store misaligned, 2 illegal func3; 0 otherwise.

Function
REQ-024 FSM states IDLE, REQ, WAIT, DONE; reset state IDLE.
REQ-025 IDLE: i_mem_access=1 with an aligned, legal access -> REQ; o_stall_mem=1 combinationally in that cycle.
REQ-026 Alignment: size 1/2/4/8 bytes requires addr[0], addr[1:0] or addr[2:0] zero respectively; byte is always aligned.
REQ-027 Misaligned or func3=7 in IDLE: no request, o_exception=1 and o_cause set combinationally, o_stall_mem=0, state stays IDLE.
REQ-028 Request fields are registered on the IDLE->REQ edge and stay constant while o_req_valid=1.
REQ-029 REQ: o_req_valid=1, o_stall_mem=1; i_req_ready=1 -> WAIT, otherwise stay in REQ.
REQ-030 The cache never asserts i_resp_valid in the acceptance cycle; i_resp_valid outside WAIT is ignored.
REQ-031 WAIT: o_stall_mem=1; i_resp_valid=1 -> DONE, capturing the extended load data into o_load_data (stores leave it unchanged).
REQ-032 DONE: o_stall_mem=0, o_done=1 for exactly one cycle, -> IDLE; a new access in the following cycle is legal.
REQ-033 Minimum latency is 4 cycles (IDLE, REQ, WAIT, DONE) with zero-wait ready and 1-cycle response.
REQ-034 Load extension: shift i_resp_data right by 8*addr[2:0], then sign-extend (func3 0-2) or zero-extend (func3 3-6, LD passes through) from the access size.
REQ-035 Store: o_req_wdata = i_write_data << 8*addr[2:0]; o_req_wstrb = {1,3,F,FF}[size] << addr[2:0].
REQ-036 o_req_addr bits [2:0] are always 0.

Reset
REQ-037 Reset forces IDLE, o_req_valid=0, o_done=0, o_load_data=0, and clears registered request fields.
REQ-038 Reset mid-transaction (REQ or WAIT) abandons the access; a later i_resp_valid is ignored.
REQ-039 o_stall_mem, o_exception and o_cause equal 0 during reset.

Structure
REQ-040 Shared package mem_pkg holds the FSM state enum, func3 encodings and cause codes 2/4/6.
REQ-041 A single combinational sub-module load_align performs the shift and extension of REQ-034.

Verification
REQ-042 LB, addr 0x1003, resp 0x0000_0000_8000_0000 -> o_load_data 0xFFFF_FFFF_FFFF_FF80, o_done in the 4th cycle.
REQ-043 SH, addr 0x2006, data 0xABCD -> o_req_addr 0x2000, wdata 0xABCD_0000_0000_0000, wstrb 0xC0.
REQ-044 LW, addr 0x1002 -> o_exception=1, o_cause=4, o_req_valid never asserted, o_stall_mem=0.
REQ-045 i_req_ready held low for 5 cycles -> request fields stable, stall held, completion 5 cycles later.
REQ-046 Reset in WAIT, then i_resp_valid pulse -> IDLE, no o_done, o_load_data=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-stage load/store unit:
// FSM states, func3 access encodings, exception cause codes and size helpers.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_D  = 3'd3;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;
  localparam logic [2:0] F3_WU = 3'd6;

  localparam logic [3:0] CAUSE_NONE        = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
  localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;

  // Size code is func3[1:0]: 0 byte, 1 half, 2 word, 3 doubleword.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] offset);
    case (size)
      2'd0:    is_misaligned = 1'b0;
      2'd1:    is_misaligned = offset[0];
      2'd2:    is_misaligned = |offset[1:0];
      default: is_misaligned = |offset;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Cache request/response bus between the memory-stage LSU (master)
// and the data cache (slave).
interface mem_stage_lsu_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [7:0]            req_wstrb;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/load_align.sv
// Combinational load aligner: moves the addressed bytes of a raw doubleword
// down to bit 0 and sign- or zero-extends them according to func3.
module load_align
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [2:0]            i_func3,
  input  logic [2:0]            i_offset,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic        [DATA_WIDTH-1:0] w_shifted;
  logic signed [7:0]            w_byte;
  logic signed [15:0]           w_half;
  logic signed [31:0]           w_word;

  assign w_shifted = i_data >> {i_offset, 3'b000};
  assign w_byte    = w_shifted[7:0];
  assign w_half    = w_shifted[15:0];
  assign w_word    = w_shifted[31:0];

  // Size casts of the signed slices sign-extend; the unsigned ones zero-extend.
  always_comb begin
    o_data = w_shifted;
    case (i_func3)
      F3_B:    o_data = DATA_WIDTH'(w_byte);
      F3_H:    o_data = DATA_WIDTH'(w_half);
      F3_W:    o_data = DATA_WIDTH'(w_word);
      F3_BU:   o_data = DATA_WIDTH'(w_shifted[7:0]);
      F3_HU:   o_data = DATA_WIDTH'(w_shifted[15:0]);
      F3_WU:   o_data = DATA_WIDTH'(w_shifted[31:0]);
      default: o_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: turns a load/store into one doubleword cache
// transaction, stalling the pipeline until the cache responds.
module mem_stage_lsu
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic                  i_mem_access,
  input  logic                  i_mem_we,
  input  logic [2:0]            i_func3,
  input  logic [ADDR_WIDTH-1:0] i_alu_result,
  input  logic [DATA_WIDTH-1:0] i_write_data,
  mem_stage_lsu_if.master       io_bus,
  output logic                  o_stall_mem,
  output logic [DATA_WIDTH-1:0] o_load_data,
  output logic                  o_done,
  output logic                  o_exception,
  output logic [3:0]            o_cause
);

  lsu_state_e            r_state;
  logic                  r_req_valid;
  logic                  r_req_we;
  logic [ADDR_WIDTH-1:0] r_req_addr;
  logic [DATA_WIDTH-1:0] r_req_wdata;
  logic [7:0]            r_req_wstrb;
  logic [2:0]            r_func3;
  logic [2:0]            r_offset;
  logic [DATA_WIDTH-1:0] r_load_data;
  logic                  r_done;

  logic [1:0]            w_size;
  logic [2:0]            w_offset;
  logic                  w_illegal;
  logic                  w_misaligned;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_aligned;

  assign w_size       = i_func3[1:0];
  assign w_offset     = i_alu_result[2:0];
  assign w_illegal    = (i_func3 == 3'd7);
  assign w_misaligned = is_misaligned(w_size, w_offset);
  assign w_accept     = (r_state == ST_IDLE) && i_mem_access && !w_illegal && !w_misaligned;

  load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
    .i_data   (io_bus.resp_data),
    .i_func3  (r_func3),
    .i_offset (r_offset),
    .o_data   (w_aligned)
  );

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      r_state     <= ST_IDLE;
      r_req_valid <= 1'b0;
      r_req_we    <= 1'b0;
      r_req_addr  <= '0;
      r_req_wdata <= '0;
      r_req_wstrb <= '0;
      r_func3     <= '0;
      r_offset    <= '0;
      r_load_data <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state     <= ST_REQ;
            r_req_valid <= 1'b1;
            r_req_we    <= i_mem_we;
            r_req_addr  <= {i_alu_result[ADDR_WIDTH-1:3], 3'b000};
            r_req_wdata <= i_write_data << {w_offset, 3'b000};
            r_req_wstrb <= size_mask(w_size) << w_offset;
            r_func3     <= i_func3;
            r_offset    <= w_offset;
          end
        end
        ST_REQ: begin
          if (io_bus.req_ready) begin
            r_state     <= ST_WAIT;
            r_req_valid <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (io_bus.resp_valid) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            if (!r_req_we) r_load_data <= w_aligned;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io_bus.req_valid = r_req_valid;
  assign io_bus.req_we    = r_req_we;
  assign io_bus.req_addr  = r_req_addr;
  assign io_bus.req_wdata = r_req_wdata;
  assign io_bus.req_wstrb = r_req_wstrb;

  assign o_load_data = r_load_data;
  assign o_done      = r_done;

  // Stall asserts in the accepting IDLE cycle so the instruction is held for the whole access.
  assign o_stall_mem = !i_arst &&
                       (w_accept || (r_state == ST_REQ) || (r_state == ST_WAIT));
  assign o_exception = !i_arst && (r_state == ST_IDLE) && i_mem_access &&
                       (w_illegal || w_misaligned);

  always_comb begin
    o_cause = CAUSE_NONE;
    if (o_exception) begin
      if (w_illegal)     o_cause = CAUSE_ILLEGAL;
      else if (i_mem_we) o_cause = CAUSE_ST_MISALIGN;
      else               o_cause = CAUSE_LD_MISALIGN;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: loads, stores, misaligned/illegal accesses,
// cache backpressure and reset in the middle of a transaction.
module tb_mem_stage_lsu;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        mem_access = 1'b0;
  logic        mem_we = 1'b0;
  logic [2:0]  func3 = 3'd0;
  logic [63:0] alu_result = '0;
  logic [63:0] write_data = '0;
  logic        stall;
  logic [63:0] load_data;
  logic        done;
  logic        exception;
  logic [3:0]  cause;

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage_lsu_if #(.DATA_WIDTH(64), .ADDR_WIDTH(64)) bus ();

  mem_stage_lsu #(.DATA_WIDTH(64), .ADDR_WIDTH(64)) dut (
    .i_clk        (clk),
    .i_arst       (arst),
    .i_mem_access (mem_access),
    .i_mem_we     (mem_we),
    .i_func3      (func3),
    .i_alu_result (alu_result),
    .i_write_data (write_data),
    .io_bus       (bus.master),
    .o_stall_mem  (stall),
    .o_load_data  (load_data),
    .o_done       (done),
    .o_exception  (exception),
    .o_cause      (cause)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] R = 64'h8899_AABB_CCDD_EEFF;

  localparam logic [2:0]  LD_F3   [9] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd6, 3'd3, 3'd0, 3'd2};
  localparam logic [63:0] LD_ADDR [9] = '{64'h1003, 64'h1005, 64'h1002, 64'h1006, 64'h1004,
                                          64'h1000, 64'h1008, 64'h1001, 64'h1000};
  localparam logic [63:0] LD_RESP [9] = '{64'h0000_0000_8000_0000, R, R, R, R, R, R,
                                          64'h0000_0000_0000_7F00, 64'h1234_5678_7654_3210};
  localparam logic [63:0] LD_EXP  [9] = '{64'hFFFF_FFFF_FFFF_FF80, 64'h0000_0000_0000_00AA,
                                          64'hFFFF_FFFF_FFFF_CCDD, 64'h0000_0000_0000_8899,
                                          64'hFFFF_FFFF_8899_AABB, 64'h0000_0000_CCDD_EEFF,
                                          R, 64'h0000_0000_0000_007F, 64'h0000_0000_7654_3210};

  localparam logic [2:0]  ST_F3    [4] = '{3'd1, 3'd0, 3'd2, 3'd3};
  localparam logic [63:0] ST_ADDR  [4] = '{64'h2006, 64'h3005, 64'h4004, 64'h5008};
  localparam logic [63:0] ST_DATA  [4] = '{64'hABCD, 64'h12EF, 64'hDEAD_BEEF, 64'h0123_4567_89AB_CDEF};
  localparam logic [63:0] ST_XADDR [4] = '{64'h2000, 64'h3000, 64'h4000, 64'h5008};
  localparam logic [63:0] ST_WDATA [4] = '{64'hABCD_0000_0000_0000, 64'h0012_EF00_0000_0000,
                                           64'hDEAD_BEEF_0000_0000, 64'h0123_4567_89AB_CDEF};
  localparam logic [7:0]  ST_STRB  [4] = '{8'hC0, 8'h20, 8'hF0, 8'hFF};

  localparam logic        MA_WE  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [2:0]  MA_F3  [6] = '{3'd2, 3'd1, 3'd3, 3'd3, 3'd7, 3'd5};
  localparam logic [63:0] MA_ADDR[6] = '{64'h1002, 64'h2001, 64'h1004, 64'h3002, 64'h0, 64'h1003};
  localparam logic [3:0]  MA_CAU [6] = '{4'd4, 4'd6, 4'd4, 4'd6, 4'd2, 4'd4};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    arst = 1'b1; mem_access = 1'b1; mem_we = 1'b0; func3 = 3'd2; alu_result = 64'h1002;
    bus.req_ready = 1'b0; bus.resp_valid = 1'b0; bus.resp_data = '0;
    step(); step();
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", stall); end
    n_checks++; if (exception !== 1'b0) begin n_fail++; $display("FAIL rst_exception: got %b want 0", exception); end
    n_checks++; if (cause !== 4'd0) begin n_fail++; $display("FAIL rst_cause: got %0d want 0", cause); end
    n_checks++; if (bus.req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid: got %b want 0", bus.req_valid); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
    n_checks++; if (load_data !== 64'h0) begin n_fail++; $display("FAIL rst_load_data: got %h want 0", load_data); end
    arst = 1'b0; mem_access = 1'b0;
  endtask

  task automatic test_loads();
    for (int i = 0; i < 9; i++) begin
      mem_access = 1'b1; mem_we = 1'b0; func3 = LD_F3[i]; alu_result = LD_ADDR[i];
      bus.req_ready = 1'b1; bus.resp_valid = 1'b0;
      #1;
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL ld%0d_accept_stall: got %b want 1", i, stall); end
      n_checks++; if (exception !== 1'b0) begin n_fail++; $display("FAIL ld%0d_exception: got %b want 0", i, exception); end
      step();
      mem_access = 1'b0;
      #1;
      n_checks++; if (bus.req_valid !== 1'b1) begin n_fail++; $display("FAIL ld%0d_req_valid: got %b want 1", i, bus.req_valid); end
      n_checks++; if (bus.req_we !== 1'b0) begin n_fail++; $display("FAIL ld%0d_req_we: got %b want 0", i, bus.req_we); end
      n_checks++; if (bus.req_addr !== (LD_ADDR[i] & ~64'h7)) begin n_fail++; $display("FAIL ld%0d_req_addr: got %h want %h", i, bus.req_addr, LD_ADDR[i] & ~64'h7); end
      step();
      bus.resp_valid = 1'b1; bus.resp_data = LD_RESP[i];
      #1;
      n_checks++; if (stall !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL ld%0d_wait: stall %b done %b want 1 0", i, stall, done); end
      step();
      bus.resp_valid = 1'b0; bus.resp_data = '0;
      #1;
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL ld%0d_done: got %b want 1", i, done); end
      n_checks++; if (load_data !== LD_EXP[i]) begin n_fail++; $display("FAIL ld%0d_load_data: got %h want %h", i, load_data, LD_EXP[i]); end
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL ld%0d_done_stall: got %b want 0", i, stall); end
      step();
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL ld%0d_done_pulse: got %b want 0", i, done); end
    end
  endtask

  task automatic test_stores();
    for (int i = 0; i < 4; i++) begin
      mem_access = 1'b1; mem_we = 1'b1; func3 = ST_F3[i]; alu_result = ST_ADDR[i]; write_data = ST_DATA[i];
      bus.req_ready = 1'b1; bus.resp_valid = 1'b0;
      #1;
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL st%0d_accept_stall: got %b want 1", i, stall); end
      step();
      mem_access = 1'b0;
      #1;
      n_checks++; if (bus.req_valid !== 1'b1 || bus.req_we !== 1'b1) begin n_fail++; $display("FAIL st%0d_req: valid %b we %b want 1 1", i, bus.req_valid, bus.req_we); end
      n_checks++; if (bus.req_addr !== ST_XADDR[i]) begin n_fail++; $display("FAIL st%0d_req_addr: got %h want %h", i, bus.req_addr, ST_XADDR[i]); end
      n_checks++; if (bus.req_wdata !== ST_WDATA[i]) begin n_fail++; $display("FAIL st%0d_wdata: got %h want %h", i, bus.req_wdata, ST_WDATA[i]); end
      n_checks++; if (bus.req_wstrb !== ST_STRB[i]) begin n_fail++; $display("FAIL st%0d_wstrb: got %h want %h", i, bus.req_wstrb, ST_STRB[i]); end
      step();
      bus.resp_valid = 1'b1; bus.resp_data = R;
      step();
      bus.resp_valid = 1'b0;
      #1;
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL st%0d_done: got %b want 1", i, done); end
      n_checks++; if (load_data !== 64'h0000_0000_7654_3210) begin n_fail++; $display("FAIL st%0d_load_kept: got %h want 0000000076543210", i, load_data); end
      step();
    end
    mem_we = 1'b0;
  endtask

  task automatic test_misaligned();
    for (int i = 0; i < 6; i++) begin
      mem_access = 1'b1; mem_we = MA_WE[i]; func3 = MA_F3[i]; alu_result = MA_ADDR[i];
      bus.req_ready = 1'b1;
      #1;
      n_checks++; if (exception !== 1'b1) begin n_fail++; $display("FAIL ma%0d_exception: got %b want 1", i, exception); end
      n_checks++; if (cause !== MA_CAU[i]) begin n_fail++; $display("FAIL ma%0d_cause: got %0d want %0d", i, cause, MA_CAU[i]); end
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL ma%0d_stall: got %b want 0", i, stall); end
      step();
      n_checks++; if (bus.req_valid !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL ma%0d_no_req: valid %b done %b want 0 0", i, bus.req_valid, done); end
    end
    mem_access = 1'b0; mem_we = 1'b0; func3 = 3'd2; alu_result = 64'h1002;
    #1;
    n_checks++; if (exception !== 1'b0 || cause !== 4'd0) begin n_fail++; $display("FAIL ma_idle_quiet: exc %b cause %0d want 0 0", exception, cause); end
  endtask

  task automatic test_backpressure();
    int cyc;
    mem_access = 1'b1; mem_we = 1'b1; func3 = 3'd2; alu_result = 64'h4004; write_data = 64'hDEAD_BEEF;
    bus.req_ready = 1'b0; bus.resp_valid = 1'b0;
    cyc = 1;
    step();
    mem_access = 1'b0; alu_result = 64'hFFFF; write_data = '0;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) bus.req_ready = 1'b1;
      #1;
      cyc++;
      n_checks++;
      if (bus.req_valid !== 1'b1 || stall !== 1'b1 || bus.req_addr !== 64'h4000 ||
          bus.req_wdata !== 64'hDEAD_BEEF_0000_0000 || bus.req_wstrb !== 8'hF0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: valid %b stall %b addr %h wdata %h strb %h want 1 1 4000 deadbeef00000000 f0",
                 k, bus.req_valid, stall, bus.req_addr, bus.req_wdata, bus.req_wstrb);
      end
      step();
    end
    bus.req_ready = 1'b0; bus.resp_valid = 1'b1;
    cyc++;
    n_checks++; if (bus.req_valid !== 1'b0 || stall !== 1'b1) begin n_fail++; $display("FAIL bp_wait: valid %b stall %b want 0 1", bus.req_valid, stall); end
    step();
    bus.resp_valid = 1'b0;
    cyc++;
    n_checks++; if (done !== 1'b1 || cyc != 9) begin n_fail++; $display("FAIL bp_done: done %b in cycle %0d want 1 in cycle 9", done, cyc); end
    step();
    mem_we = 1'b0;
  endtask

  task automatic test_reset_mid();
    mem_access = 1'b1; mem_we = 1'b0; func3 = 3'd3; alu_result = 64'h6000;
    bus.req_ready = 1'b1; bus.resp_valid = 1'b0;
    step();
    mem_access = 1'b0;
    step();
    arst = 1'b1;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rm_stall_in_reset: got %b want 0", stall); end
    step();
    arst = 1'b0;
    #1;
    n_checks++; if (bus.req_valid !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL rm_idle: valid %b stall %b want 0 0", bus.req_valid, stall); end
    bus.resp_valid = 1'b1; bus.resp_data = R;
    step();
    bus.resp_valid = 1'b0;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rm_no_done: got %b want 0", done); end
    n_checks++; if (load_data !== 64'h0) begin n_fail++; $display("FAIL rm_load_data: got %h want 0", load_data); end
    step();
    n_checks++; if (done !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL rm_quiet: done %b stall %b want 0 0", done, stall); end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_misaligned();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
